// File: rtl/uproc_pkg.sv
// Shared uProcessor datapath definitions: register-file geometry, data/index types
// and the one-hot register select decoder.
package uproc_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;

    // Out-of-range indices decode to all zeros, so they never select a register.
    function automatic logic [NUM_REGS-1:0] onehot_dec(input reg_idx_t idx);
        logic [NUM_REGS-1:0] dec;
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                dec[i] = 1'b1;
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first eligible requester found
// after i_last, wrapping modulo N, as both a one-hot vector and a binary index.
module rr_picker #(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_last,
    output logic [N-1:0]     o_winner,
    output logic [PTR_W-1:0] o_winnerIdx,
    output logic             o_valid
);

    // Scan starts one past the last winner so the most recent grantee has lowest priority.
    always_comb begin
        int cand;
        o_valid     = 1'b0;
        o_winnerIdx = '0;
        cand        = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(i_last) + k) % N;
            if (!o_valid && i_eligible[cand]) begin
                o_valid     = 1'b1;
                o_winnerIdx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        o_winner = '0;
        if (o_valid) begin
            o_winner[o_winnerIdx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NUM_REQ
// writers; one registered write per clock.
module regfile_write_arbiter #(
    parameter  int NUM_REQ  = 3,
    parameter  int DATA_W   = uproc_pkg::DATA_W,
    parameter  int NUM_REGS = uproc_pkg::NUM_REGS,
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*IDX_W-1:0]  i_reqReg,
    input  logic [NUM_REQ*DATA_W-1:0] i_reqData,
    input  logic                      i_hold,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [DATA_W-1:0]         o_a,
    output logic [NUM_REGS-1:0]       o_regNum,
    output logic                      o_regCE,
    output logic                      o_idxErr
);

    logic [NUM_REQ-1:0]  r_gnt;
    logic [DATA_W-1:0]   r_a;
    logic [NUM_REGS-1:0] r_regNum;
    logic                r_regCE;
    logic                r_idxErr;
    logic [PTR_W-1:0]    r_last;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_winner;
    logic [PTR_W-1:0]    w_winIdx;
    logic                w_valid;
    logic [DATA_W-1:0]   w_selData;
    logic [IDX_W-1:0]    w_selReg;
    logic [NUM_REGS-1:0] w_regDec;
    logic                w_idxOk;

    // The current grantee is masked so a lingering request cannot write twice.
    assign w_eligible = i_req & ~r_gnt & {NUM_REQ{~i_hold}};

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .i_eligible  (w_eligible),
        .i_last      (r_last),
        .o_winner    (w_winner),
        .o_winnerIdx (w_winIdx),
        .o_valid     (w_valid)
    );

    assign w_selData = i_reqData[int'(w_winIdx)*DATA_W +: DATA_W];
    assign w_selReg  = i_reqReg[int'(w_winIdx)*IDX_W +: IDX_W];

    // An index with no matching register leaves the decode empty, which flags the error.
    always_comb begin
        w_regDec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_selReg == IDX_W'(i)) begin
                w_regDec[i] = 1'b1;
            end
        end
    end

    assign w_idxOk = |w_regDec;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_gnt    <= '0;
            r_a      <= '0;
            r_regNum <= '0;
            r_regCE  <= 1'b0;
            r_idxErr <= 1'b0;
            r_last   <= PTR_W'(NUM_REQ - 1);
        end else if (w_valid) begin
            r_gnt    <= w_winner;
            r_a      <= w_selData;
            r_regNum <= w_idxOk ? w_regDec : '0;
            r_regCE  <= w_idxOk;
            r_idxErr <= ~w_idxOk;
            r_last   <= w_winIdx;
        end else begin
            r_gnt    <= '0;
            r_regNum <= '0;
            r_regCE  <= 1'b0;
            r_idxErr <= 1'b0;
        end
    end

    assign o_gnt    = r_gnt;
    assign o_a      = r_a;
    assign o_regNum = r_regNum;
    assign o_regCE  = r_regCE;
    assign o_idxErr = r_idxErr;

endmodule
